// File: rtl/multicycle_exec_core.sv
// Multi-cycle instruction executor: latches one instruction per done pulse,
// runs it on a small register file and pulses done again when finished.
module multicycle_exec_core #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    instr,
  input  logic [4:0]    reg1,
  input  logic [4:0]    reg2,
  input  logic [4:0]    reg3,
  input  logic [DW-1:0] const_val,
  output logic          done,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int unsigned CW = $clog2(DW);

  localparam logic [2:0] OpLi   = 3'b000;
  localparam logic [2:0] OpOut  = 3'b001;
  localparam logic [2:0] OpSwap = 3'b010;
  localparam logic [2:0] OpAddi = 3'b011;
  localparam logic [2:0] OpAdd3 = 3'b100;
  localparam logic [2:0] OpSub  = 3'b101;
  localparam logic [2:0] OpMul  = 3'b110;
  localparam logic [2:0] OpShl  = 3'b111;

  typedef enum logic [2:0] {StIssue, StFetch, StExec, StWb, StWb2, StMult} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [4:0]    ra_q, rb_q, rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] res_q, res2_q;
  logic [DW-1:0] mcand_q, mplier_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] out_data_q;
  logic          done_q, out_valid_q;
  logic [DW-1:0] opa, opb;
  logic [4:0]    wa;

  // R0 is never written and resets to zero, so it always reads 0.
  assign opa = rf_q[ra_q];
  assign opb = rf_q[rb_q];
  // SWAP's first write targets reg1; everything else writes reg3.
  assign wa  = (op_q == OpSwap) ? ra_q : rd_q;

  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIssue;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIssue: state_d = StFetch;
      StFetch: state_d = StExec;
      StExec:  state_d = (op_q == OpMul) ? StMult : StWb;
      StMult:  if (cnt_q == CW'(DW - 1)) state_d = StWb;
      StWb:    state_d = (op_q == OpSwap) ? StWb2 : StIssue;
      StWb2:   state_d = StIssue;
      default: state_d = StIssue;
    endcase
  end

  // Registered handshake outputs, aligned with the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      done_q      <= (state_d == StIssue);
      out_valid_q <= (state_d == StWb) && (op_q == OpOut);
    end
  end

  // Instruction latch, ALU, shift-add multiplier and OUT capture.
  // out_data is loaded on entry to WB so it is already valid while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OpLi;
      ra_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      res2_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          op_q  <= instr;
          ra_q  <= reg1;
          rb_q  <= reg2;
          rd_q  <= reg3;
          imm_q <= const_val;
        end
        StExec: begin
          unique case (op_q)
            OpLi:   res_q <= imm_q;
            OpOut:  out_data_q <= opa;
            OpSwap: begin
              res_q  <= opb;
              res2_q <= opa;
            end
            OpAddi: res_q <= opa + imm_q;
            OpAdd3: res_q <= opa + opb + imm_q;
            OpSub:  res_q <= opa - opb;
            OpMul: begin
              res_q    <= '0;
              mcand_q  <= opa;
              mplier_q <= opb;
              cnt_q    <= '0;
            end
            OpShl:  res_q <= opa << imm_q[3:0];
            default: res_q <= res_q;
          endcase
        end
        StMult: begin
          if (mplier_q[0]) res_q <= res_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file write-back; R0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == StWb && op_q != OpOut && wa != '0) begin
      rf_q[wa] <= res_q;
    end else if (state_q == StWb2 && rb_q != '0) begin
      rf_q[rb_q] <= res2_q;
    end
  end

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Self-checking bench for multicycle_exec_core with a behavioural register-file model.
module tb_multicycle_exec_core;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic [15:0] c;
    logic [15:0] e;  // expected out_data for OUT entries
  } ins_t;

  localparam logic [2:0] LI = 3'd0, OUT = 3'd1, SWAP = 3'd2, ADDI = 3'd3;
  localparam logic [2:0] ADD3 = 3'd4, SUB = 3'd5, MUL = 3'd6, SHL = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  instr = '0;
  logic [4:0]  reg1 = '0, reg2 = '0, reg3 = '0;
  logic [15:0] const_val = '0;
  logic        done, out_valid;
  logic [15:0] out_data;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ov_count = 0;
  logic [15:0] ov_data = '0;
  int          t_issue = 0;
  int          t_done = 0;
  logic [15:0] m_rf [32];
  logic [15:0] m_out = '0;

  multicycle_exec_core #(.DW(16), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .reg1      (reg1),
    .reg2      (reg2),
    .reg3      (reg3),
    .const_val (const_val),
    .done      (done),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_count <= ov_count + 1;
      ov_data  <= out_data;
    end
  end

  // Reference model: architectural effect of one instruction.
  task automatic model_wr(input logic [4:0] r, input logic [15:0] v);
    if (r != 0) m_rf[r] = v;
  endtask

  task automatic model_exec(input ins_t i);
    logic [15:0] x, y;
    logic [31:0] p;
    x = m_rf[i.a];
    y = m_rf[i.b];
    case (i.op)
      LI:   model_wr(i.d, i.c);
      OUT:  m_out = x;
      SWAP: begin model_wr(i.a, y); model_wr(i.b, x); end
      ADDI: model_wr(i.d, x + i.c);
      ADD3: model_wr(i.d, x + y + i.c);
      SUB:  model_wr(i.d, x - y);
      MUL:  begin p = x * y; model_wr(i.d, p[15:0]); end
      default: model_wr(i.d, x << i.c[3:0]);
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    if (op == MUL) return 4 + 16;
    if (op == SWAP) return 5;
    return 4;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    instr = LI; reg1 = '0; reg2 = '0; reg3 = '0; const_val = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at a negedge with done high (or immediately if already there).
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    t_done = cyc;
    if (done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  // Drive one instruction in the ISSUE cycle; scramble inputs once it is latched.
  task automatic issue(input ins_t i);
    wait_done();
    t_issue = cyc;
    instr = i.op; reg1 = i.a; reg2 = i.b; reg3 = i.d; const_val = i.c;
    @(posedge clk);
    @(posedge clk);
    #1;
    instr = 3'($urandom); reg1 = 5'($urandom); reg2 = 5'($urandom);
    reg3 = 5'($urandom); const_val = 16'($urandom);
    model_exec(i);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 3;
    if (done !== 1'b1) begin n_err++; $display("FAIL reset_done: got %b want 1", done); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_od: got %h want 0000", out_data); end
    issue('{LI, 5'd0, 5'd0, 5'd1, 16'd3, 16'd0});
    issue('{LI, 5'd0, 5'd0, 5'd2, 16'd5, 16'd0});
    issue('{MUL, 5'd1, 5'd2, 5'd3, 16'd0, 16'd0});
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL mul_busy: done=%b want 0", done); end
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (done !== 1'b1) begin n_err++; $display("FAIL midmul_done: got %b want 1", done); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midmul_ov: got %b want 0", out_valid); end
    do_reset();
    for (int r = 3; r >= 1; r -= 2) begin
      int pb;
      pb = ov_count;
      issue('{OUT, 5'(r), 5'd0, 5'd0, 16'd0, 16'd0});
      wait_done();
      n_cmp += 2;
      if (out_data !== 16'h0) begin n_err++; $display("FAIL midmul_r%0d: got %h want 0000", r, out_data); end
      if (ov_count - pb != 1) begin n_err++; $display("FAIL midmul_pulse: got %0d want 1", ov_count - pb); end
    end
  endtask

  task automatic test_program();
    ins_t p [18];
    p = '{'{LI, 5'd0, 5'd0, 5'd1, 16'd17, 16'd0},
          '{ADDI, 5'd1, 5'd0, 5'd2, 16'hFFF7, 16'd0},
          '{ADD3, 5'd1, 5'd2, 5'd3, 16'd65, 16'd0},
          '{OUT, 5'd1, 5'd0, 5'd0, 16'd0, 16'd17},
          '{OUT, 5'd2, 5'd0, 5'd0, 16'd0, 16'd8},
          '{OUT, 5'd3, 5'd0, 5'd0, 16'd0, 16'd90},
          '{SWAP, 5'd2, 5'd3, 5'd0, 16'd0, 16'd0},
          '{OUT, 5'd2, 5'd0, 5'd0, 16'd0, 16'd90},
          '{OUT, 5'd3, 5'd0, 5'd0, 16'd0, 16'd8},
          '{SHL, 5'd3, 5'd0, 5'd5, 16'd3, 16'd0},
          '{OUT, 5'd5, 5'd0, 5'd0, 16'd0, 16'd64},
          '{SUB, 5'd1, 5'd2, 5'd4, 16'd0, 16'd0},
          '{OUT, 5'd4, 5'd0, 5'd0, 16'd0, 16'hFFB7},
          '{SHL, 5'd4, 5'd0, 5'd4, 16'd9, 16'd0},
          '{OUT, 5'd4, 5'd0, 5'd0, 16'd0, 16'h6E00},
          '{MUL, 5'd5, 5'd4, 5'd6, 16'd0, 16'd0},
          '{OUT, 5'd6, 5'd0, 5'd0, 16'd0, 16'h8000},
          '{LI, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0}};
    do_reset();
    foreach (p[k]) begin
      int pb;
      pb = ov_count;
      issue(p[k]);
      wait_done();
      n_cmp++;
      if (p[k].op == OUT) begin
        n_cmp++;
        if (out_data !== p[k].e || ov_data !== p[k].e) begin
          n_err++; $display("FAIL prog_out[%0d]: got %h/%h want %h", k, out_data, ov_data, p[k].e);
        end
        if (ov_count - pb != 1) begin n_err++; $display("FAIL prog_pulse[%0d]: got %0d want 1", k, ov_count - pb); end
      end else if (ov_count - pb != 0) begin
        n_err++; $display("FAIL prog_nopulse[%0d]: got %0d want 0", k, ov_count - pb);
      end
    end
  endtask

  task automatic test_r0_and_overflow();
    ins_t p [15];
    p = '{'{LI, 5'd0, 5'd0, 5'd0, 16'd5, 16'd0},
          '{OUT, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0},
          '{LI, 5'd0, 5'd0, 5'd1, 16'd7, 16'd0},
          '{SWAP, 5'd0, 5'd1, 5'd0, 16'd0, 16'd0},
          '{OUT, 5'd1, 5'd0, 5'd0, 16'd0, 16'd0},
          '{OUT, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0},
          '{LI, 5'd0, 5'd0, 5'd1, 16'hFFFF, 16'd0},
          '{ADDI, 5'd1, 5'd0, 5'd2, 16'd1, 16'd0},
          '{OUT, 5'd2, 5'd0, 5'd0, 16'd0, 16'd0},
          '{LI, 5'd0, 5'd0, 5'd3, 16'h0100, 16'd0},
          '{MUL, 5'd3, 5'd3, 5'd4, 16'd0, 16'd0},
          '{OUT, 5'd4, 5'd0, 5'd0, 16'd0, 16'd0},
          '{LI, 5'd0, 5'd0, 5'd5, 16'h00A5, 16'd0},
          '{SHL, 5'd5, 5'd0, 5'd6, 16'h0013, 16'd0},
          '{OUT, 5'd6, 5'd0, 5'd0, 16'd0, 16'h0528}};
    do_reset();
    foreach (p[k]) begin
      issue(p[k]);
      wait_done();
      if (p[k].op == OUT) begin
        n_cmp++;
        if (out_data !== p[k].e) begin
          n_err++; $display("FAIL edge_out[%0d]: got %h want %h", k, out_data, p[k].e);
        end
      end
    end
  endtask

  task automatic test_timing();
    ins_t p [5];
    p = '{'{LI, 5'd0, 5'd0, 5'd1, 16'd9, 16'd0},
          '{ADDI, 5'd1, 5'd0, 5'd2, 16'd4, 16'd0},
          '{SWAP, 5'd1, 5'd2, 5'd0, 16'd0, 16'd0},
          '{MUL, 5'd1, 5'd2, 5'd3, 16'd0, 16'd0},
          '{OUT, 5'd3, 5'd0, 5'd0, 16'd0, 16'd0}};
    do_reset();
    foreach (p[k]) begin
      issue(p[k]);
      wait_done();
      n_cmp++;
      if (t_done - t_issue != exp_lat(p[k].op)) begin
        n_err++; $display("FAIL latency op%0d: got %0d want %0d", p[k].op, t_done - t_issue,
                          exp_lat(p[k].op));
      end
    end
    n_cmp++;
    if (out_data !== 16'd117) begin n_err++; $display("FAIL timing_mul: got %h want 0075", out_data); end
  endtask

  task automatic test_random();
    ins_t i;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      int pb;
      i.op = 3'($urandom);
      i.a  = 5'($urandom_range(0, 7));
      i.b  = 5'($urandom_range(0, 7));
      i.d  = 5'($urandom_range(0, 7));
      i.c  = 16'($urandom);
      i.e  = '0;
      pb = ov_count;
      issue(i);
      wait_done();
      n_cmp += 2;
      if (t_done - t_issue != exp_lat(i.op)) begin
        n_err++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", k, t_done - t_issue, exp_lat(i.op));
      end
      if (ov_count - pb != ((i.op == OUT) ? 1 : 0)) begin
        n_err++; $display("FAIL rnd_pulse[%0d]: got %0d", k, ov_count - pb);
      end
      if (i.op == OUT) begin
        n_cmp++;
        if (out_data !== m_out || ov_data !== m_out) begin
          n_err++; $display("FAIL rnd_out[%0d]: got %h/%h want %h", k, out_data, ov_data, m_out);
        end
      end
    end
    for (int r = 0; r < 8; r++) begin
      issue('{OUT, 5'(r), 5'd0, 5'd0, 16'd0, 16'd0});
      wait_done();
      n_cmp++;
      if (out_data !== m_rf[r]) begin
        n_err++; $display("FAIL rnd_reg%0d: got %h want %h", r, out_data, m_rf[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_r0_and_overflow();
    test_timing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
